// File: rtl/riscv_definitions.sv
`default_nettype none
// ============================================================================
// Package     : riscv_definitions
// Description : Shared types and constants for the instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_definitions;

  // Fetch controller states
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_t;

  // First fetch address after reset unless overridden at instantiation
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Force an address onto a 32-bit word boundary
  function automatic logic [31:0] align_word(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer
// Description : Small circular FIFO of {instruction, pc} pairs sitting between
//               instruction memory responses and decode. Flush empties it in
//               one cycle and has priority over push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer #(
  parameter int DEPTH = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_push,
  input  logic [31:0]                  i_push_instr,
  input  logic [31:0]                  i_push_pc,
  input  logic                         i_pop,
  input  logic                         i_flush,
  output logic [31:0]                  o_instr,
  output logic [31:0]                  o_pc,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign do_push = i_push && (count_q != FULL_COUNT);
  assign do_pop  = i_pop  && (count_q != '0);

  // Entry storage, pointer and occupancy bookkeeping
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else if (i_flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        instr_q[wr_ptr_q] <= i_push_instr;
        pc_q[wr_ptr_q]    <= i_push_pc;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign o_instr = instr_q[rd_ptr_q];
  assign o_pc    = pc_q[rd_ptr_q];
  assign o_full  = (count_q == FULL_COUNT);
  assign o_empty = (count_q == '0);
  assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Sequential instruction fetcher with credit-limited memory
//               requests, an instruction buffer toward decode, and redirect
//               handling that drops stale in-flight responses via a kill count.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import riscv_definitions::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_misaligned
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int UW = CW + 1;
  localparam logic [UW-1:0] CREDIT_LIMIT = UW'(BUF_DEPTH);

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d;          // next address to request
  logic [31:0]   rsp_pc_q, rsp_pc_d;  // address of the next live response
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] kill_q, kill_d;
  logic [CW-1:0] out_next;
  logic          misaligned_q, misaligned_d;

  logic [31:0]   buf_instr;
  logic [31:0]   buf_pc;
  logic          buf_full;
  logic          buf_empty;
  logic [CW-1:0] buf_count;

  logic [UW-1:0] credit_used;
  logic          req_valid;
  logic          req_fire;
  logic          instr_valid;
  logic          pop;
  logic          push;
  logic          flush;

  // Decode never sees a handshake in a redirect cycle. A same-cycle pop frees
  // a buffer slot before any new request can respond, so it releases a credit
  // immediately; this keeps one instruction per cycle with a 1-cycle memory.
  assign instr_valid = !buf_empty && !i_redirect_valid;
  assign pop         = instr_valid && i_instr_ready;
  assign credit_used = UW'(outstanding_q) + UW'(buf_count) - UW'(pop);
  assign req_valid   = (state_q != ST_BOOT) && (credit_used < CREDIT_LIMIT);
  assign req_fire    = req_valid && i_imem_req_ready;

  // Next-state: PCs, credit/kill counters, buffer push/flush, FSM transition
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    rsp_pc_d      = rsp_pc_q;
    kill_d        = kill_q;
    misaligned_d  = 1'b0;
    push          = 1'b0;
    flush         = 1'b0;
    out_next      = outstanding_q + CW'(req_fire) - CW'(i_imem_rsp_valid);
    outstanding_d = out_next;

    if (i_redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path,
      // including a request accepted right now at the old PC.
      flush        = 1'b1;
      pc_d         = align_word(i_redirect_pc);
      rsp_pc_d     = align_word(i_redirect_pc);
      kill_d       = out_next;
      misaligned_d = |i_redirect_pc[1:0];
      state_d      = (out_next != '0) ? ST_FLUSH : ST_RUN;
    end else begin
      if (req_fire) begin
        pc_d = pc_q + 32'd4;
      end
      if (i_imem_rsp_valid) begin
        if (kill_q != '0) begin
          kill_d = kill_q - CW'(1);
        end else begin
          push     = !buf_full;
          rsp_pc_d = rsp_pc_q + 32'd4;
        end
      end
      case (state_q)
        ST_BOOT:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_RUN;
        ST_FLUSH: state_d = (kill_d == '0) ? ST_RUN : ST_FLUSH;
        default:  state_d = ST_BOOT;
      endcase
    end
  end

  // Controller registers with asynchronous reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      kill_q        <= '0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      kill_q        <= kill_d;
      misaligned_q  <= misaligned_d;
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buffer (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_push       (push),
    .i_push_instr (i_imem_rsp_data),
    .i_push_pc    (rsp_pc_q),
    .i_pop        (pop),
    .i_flush      (flush),
    .o_instr      (buf_instr),
    .o_pc         (buf_pc),
    .o_full       (buf_full),
    .o_empty      (buf_empty),
    .o_count      (buf_count)
  );

  assign o_imem_req_valid = req_valid;
  assign o_imem_addr      = pc_q;
  assign o_instr_valid    = instr_valid;
  assign o_instr          = buf_empty ? 32'h0 : buf_instr;
  assign o_pc             = buf_empty ? 32'h0 : buf_pc;
  assign o_misaligned     = misaligned_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit with a latency-configurable
//               in-order memory model and an expected-PC scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_ready = 1'b1;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_ready = 1'b1;
  logic        req_valid_o;
  logic [31:0] addr_o;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        mis_o;

  always #5 clk = ~clk;

  fetch_unit dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .o_imem_req_valid (req_valid_o),
    .i_imem_req_ready (req_ready),
    .o_imem_addr      (addr_o),
    .i_imem_rsp_valid (rsp_valid),
    .i_imem_rsp_data  (rsp_data),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_instr_valid    (instr_valid_o),
    .i_instr_ready    (instr_ready),
    .o_instr          (instr_o),
    .o_pc             (pc_o),
    .o_misaligned     (mis_o)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int n_req = 0;
  int n_cons = 0;
  int lat = 1;
  logic [31:0] exp_q[$];
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  logic        s_req_valid, s_ivalid, s_mis;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0000_0013;
  endfunction

  task automatic expect_stream(input logic [31:0] start);
    exp_q.delete();
    for (int k = 0; k < 128; k++) exp_q.push_back(start + 32'(4 * k));
  endtask

  // One clock: drive memory response, sample before the edge, record traffic
  task automatic step();
    logic [31:0] e;
    if (rst_n && mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = mem_word(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = '0;
    end
    #4;
    s_req_valid = req_valid_o;
    s_addr      = addr_o;
    s_ivalid    = instr_valid_o;
    s_pc        = pc_o;
    s_instr     = instr_o;
    s_mis       = mis_o;
    if (rst_n && s_req_valid && req_ready) begin
      mem_addr_q.push_back(s_addr);
      mem_due_q.push_back(cyc + lat);
      n_req++;
    end
    if (rst_n && s_ivalid && instr_ready) begin
      n_cons++;
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: pc=%h instr=%h but nothing expected", s_pc, s_instr);
      end else begin
        e = exp_q.pop_front();
        if (s_pc !== e || s_instr !== mem_word(e))
          $display("FAIL sb_instr: pc=%h instr=%h expected pc=%h instr=%h", s_pc, s_instr, e, mem_word(e));
        else n_pass++;
      end
    end
    if (rst_n && redirect_valid) expect_stream({redirect_pc[31:2], 2'b00});
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    mem_addr_q.delete();
    mem_due_q.delete();
    exp_q.delete();
    step();
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_total++; if (req_valid_o !== 1'b0) $display("FAIL rst_req_valid: got %b expected 0", req_valid_o); else n_pass++;
    n_total++; if (instr_valid_o !== 1'b0) $display("FAIL rst_instr_valid: got %b expected 0", instr_valid_o); else n_pass++;
    n_total++; if (mis_o !== 1'b0) $display("FAIL rst_misaligned: got %b expected 0", mis_o); else n_pass++;
    n_total++; if (instr_o !== 32'h0) $display("FAIL rst_instr: got %h expected 0", instr_o); else n_pass++;
    n_total++; if (pc_o !== 32'h0) $display("FAIL rst_pc: got %h expected 0", pc_o); else n_pass++;
    @(negedge clk);
    apply_reset();
  endtask

  task automatic test_boot_throughput();
    apply_reset();
    lat = 1; instr_ready = 1'b1; req_ready = 1'b1;
    expect_stream(32'h0);
    rst_n = 1'b1;
    n_cons = 0;
    step();
    n_total++; if (s_req_valid !== 1'b0) $display("FAIL boot_no_req: got %b expected 0", s_req_valid); else n_pass++;
    step();
    n_total++; if (s_req_valid !== 1'b1 || s_addr !== 32'h0) $display("FAIL first_req: valid=%b addr=%h expected 1/00000000", s_req_valid, s_addr); else n_pass++;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++;
      if (s_ivalid !== 1'b1 || s_pc !== 32'(4 * i))
        $display("FAIL boot_pc_seq: valid=%b pc=%h expected 1/%h", s_ivalid, s_pc, 32'(4 * i));
      else n_pass++;
    end
    for (int i = 0; i < 20; i++) step();
    n_total++; if (n_cons != 23) $display("FAIL throughput: consumed %0d expected 23", n_cons); else n_pass++;
  endtask

  task automatic test_stall();
    apply_reset();
    lat = 1; instr_ready = 1'b0;
    expect_stream(32'h0);
    rst_n = 1'b1;
    step();
    n_req = 0;
    for (int i = 2; i <= 6; i++) begin
      step();
      if (i >= 4) begin
        n_total++;
        if (s_ivalid !== 1'b1 || s_pc !== 32'h0 || s_instr !== mem_word(32'h0))
          $display("FAIL stall_hold: valid=%b pc=%h instr=%h expected 1/00000000/%h", s_ivalid, s_pc, s_instr, mem_word(32'h0));
        else n_pass++;
      end
    end
    n_total++; if (n_req != 2) $display("FAIL stall_requests: got %0d expected 2", n_req); else n_pass++;
    instr_ready = 1'b1;
    n_cons = 0;
    for (int i = 0; i < 10; i++) step();
    n_total++; if (n_cons != 10) $display("FAIL stall_release: consumed %0d expected 10", n_cons); else n_pass++;
  endtask

  task automatic test_redirect_flush();
    bit seen;
    apply_reset();
    lat = 3; instr_ready = 1'b1;
    expect_stream(32'h0);
    rst_n = 1'b1;
    step(); step(); step();
    n_total++; if (mem_addr_q.size() != 2) $display("FAIL two_outstanding: got %0d expected 2", mem_addr_q.size()); else n_pass++;
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    n_cons = 0; seen = 1'b0;
    for (int k = 0; k < 30 && n_cons < 2; k++) begin
      step();
      if (!seen && s_req_valid && req_ready) begin
        seen = 1'b1;
        n_total++; if (s_addr !== 32'h100) $display("FAIL redir_req_addr: got %h expected 00000100", s_addr); else n_pass++;
      end
    end
    n_total++; if (n_cons < 2) $display("FAIL redir_resume: consumed %0d expected 2", n_cons); else n_pass++;
  endtask

  task automatic test_misaligned_and_collision();
    apply_reset();
    lat = 1; instr_ready = 1'b1;
    expect_stream(32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step();
    redirect_valid = 1'b1; redirect_pc = 32'h202;
    step();
    redirect_valid = 1'b0;
    n_total++; if (s_ivalid !== 1'b0) $display("FAIL redirect_blocks_decode: got %b expected 0", s_ivalid); else n_pass++;
    step();
    n_total++; if (s_mis !== 1'b1) $display("FAIL mis_pulse: got %b expected 1", s_mis); else n_pass++;
    n_total++; if (s_req_valid !== 1'b1 || s_addr !== 32'h200) $display("FAIL aligned_fetch: valid=%b addr=%h expected 1/00000200", s_req_valid, s_addr); else n_pass++;
    // Redirect while the 0x200 response arrives and 0x204 is being accepted
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    step();
    redirect_valid = 1'b0;
    n_total++; if (s_mis !== 1'b0) $display("FAIL mis_one_cycle: got %b expected 0", s_mis); else n_pass++;
    n_total++;
    if (s_req_valid !== 1'b1 || s_addr !== 32'h204 || rsp_valid !== 1'b1)
      $display("FAIL collision_setup: req=%b addr=%h rsp=%b expected 1/00000204/1", s_req_valid, s_addr, rsp_valid);
    else n_pass++;
    n_cons = 0;
    for (int k = 0; k < 20 && n_cons < 3; k++) step();
    n_total++; if (n_cons < 3) $display("FAIL collision_resume: consumed %0d expected 3", n_cons); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    lat = 3; instr_ready = 1'b1;
    expect_stream(32'h0);
    rst_n = 1'b1;
    step(); step(); step();
    n_total++; if (mem_addr_q.size() != 2) $display("FAIL mid_outstanding: got %0d expected 2", mem_addr_q.size()); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (req_valid_o !== 1'b0 || instr_valid_o !== 1'b0 || mis_o !== 1'b0 || instr_o !== 32'h0 || pc_o !== 32'h0)
      $display("FAIL mid_reset_outputs: req=%b iv=%b mis=%b instr=%h pc=%h expected all 0", req_valid_o, instr_valid_o, mis_o, instr_o, pc_o);
    else n_pass++;
    mem_addr_q.delete(); mem_due_q.delete(); exp_q.delete();
    @(negedge clk);
    step();
    lat = 1;
    expect_stream(32'h0);
    rst_n = 1'b1;
    step();
    step();
    n_total++; if (s_req_valid !== 1'b1 || s_addr !== 32'h0) $display("FAIL restart_addr: valid=%b addr=%h expected 1/00000000", s_req_valid, s_addr); else n_pass++;
    n_cons = 0;
    for (int k = 0; k < 20 && n_cons < 3; k++) step();
    n_total++; if (n_cons < 3) $display("FAIL restart_resume: consumed %0d expected 3", n_cons); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_boot_throughput();
    test_stall();
    test_redirect_flush();
    test_misaligned_and_collision();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, meaning instruction buffer entries and max outstanding requests.
REQ-003 SHALL have port i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port o_imem_req_valid  output  1  fetch request valid.
REQ-006 SHALL have port i_imem_req_ready  input  1  memory accepts request.
REQ-007 SHALL have port o_imem_addr  output  32  word-aligned fetch address.
REQ-008 SHALL have port i_imem_rsp_valid  input  1  response valid; always accepted; in order; at least 1 cycle after acceptance.
REQ-009 SHALL have port i_imem_rsp_data  input  32  fetched instruction word.
REQ-010 SHALL have port i_redirect_valid  input  1  branch/jump redirect strobe.
REQ-011 SHALL have port i_redirect_pc  input  32  redirect target.
REQ-012 SHALL have port o_instr_valid  output  1  instruction available to decode.
REQ-013 SHALL have port i_instr_ready  input  1  decode accepts (deasserted = stall).
REQ-014 SHALL have port o_instr  output  32  instruction; bits [31:7] feed the immediate sign-extender.
REQ-015 SHALL have port o_pc  output  32  address of o_instr.
REQ-016 SHALL have port o_misaligned  output  1  one-cycle pulse: redirect target had pc[1:0] != 0.

Function
REQ-017 SHALL implement FSM states ST_BOOT, ST_RUN, ST_FLUSH.
REQ-018 ST_BOOT: no requests; unconditional transition to ST_RUN on first clock after reset release.
REQ-019 o_imem_req_valid SHALL be 1 only in ST_RUN/ST_FLUSH and only when outstanding + buffered < BUF_DEPTH.
REQ-020 o_imem_addr SHALL equal fetch PC; request handshake = valid & ready; on handshake fetch PC <= PC + 4 (wraps at 2^32), outstanding +1.
REQ-021 A live response SHALL push {data, address} into the buffer; buffer never overflows (credit rule REQ-019).
REQ-022 o_instr/o_pc SHALL present buffer head; o_instr_valid = buffer not empty and no redirect this cycle; pop on valid & ready.
REQ-023 Zero-bubble throughput: with ready memory (1-cycle response) and decode ready, one instruction per cycle sustained.
REQ-024 Redirect SHALL: flush buffer; fetch PC <= {i_redirect_pc[31:2], 2'b00}; kill counter <= outstanding after this cycle's request/response updates; enter ST_FLUSH if result > 0, else ST_RUN.
REQ-025 Response arriving in redirect cycle SHALL be discarded; request accepted in redirect cycle (old PC) SHALL be counted in kill counter.
REQ-026 In ST_FLUSH responses SHALL decrement kill counter and be discarded; new requests to redirected PC permitted; return to ST_RUN when counter reaches 0.
REQ-027 Redirect during ST_FLUSH SHALL recompute kill counter per REQ-024.
REQ-028 Redirect has priority over request-handshake PC increment.
REQ-029 Decode handshake in a redirect cycle SHALL not occur (o_instr_valid forced 0).
REQ-030 o_misaligned SHALL pulse the cycle after a redirect whose pc[1:0] != 0.

Reset
REQ-031 Reset asserted SHALL immediately force: state ST_BOOT, fetch PC RESET_PC, outstanding 0, kill 0, buffer empty, o_imem_req_valid 0, o_instr_valid 0, o_misaligned 0, o_instr 0, o_pc 0.
REQ-032 Reset mid-operation SHALL abandon in-flight requests; memory is reset together with this block.

Structure
REQ-033 fetch_state_t enum and RESET_PC default constant SHALL reside in riscv_definitions.
REQ-034 Buffer SHALL be sub-module fetch_buffer (BUF_DEPTH-entry FIFO of {instr, pc}, push/pop/flush, full/empty).

Verification
REQ-035 Reset release, memory ready, 1-cycle response, decode ready -> first request addr 0x0 on cycle 2; o_pc sequence 0x0,0x4,0x8 on consecutive cycles.
REQ-036 i_instr_ready held 0 for 5 cycles -> exactly 2 requests issued, o_instr/o_pc stable; release -> no instruction lost or duplicated.
REQ-037 Redirect to 0x100 with 2 requests outstanding -> both responses discarded; next o_pc 0x100 then 0x104.
REQ-038 Redirect to 0x202 -> o_misaligned pulse next cycle; fetch proceeds from 0x200.
REQ-039 Redirect in same cycle as response and request accept -> response dropped, old-PC request killed, first valid o_pc = target.
REQ-040 Assert i_rst_n low with 2 outstanding -> all outputs reset immediately; after release fetch restarts at RESET_PC.
